// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default bit timing.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to the idle-high level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    assign dout = sync_reg;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling driven by a bit-cycle counter, with framing-error detection.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s;
    state_t        state_reg,  state_next;
    logic [CW-1:0] cnt_reg,    cnt_next;
    logic [2:0]    idx_reg,    idx_next;
    logic [7:0]    shift_reg,  shift_next;
    logic [7:0]    data_reg,   data_next;
    logic          valid_reg,  valid_next;
    logic          ferr_reg,   ferr_next;

    sync_2ff u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx),
        .dout (rx_s)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                // Half a bit in: a line that has gone high again was only a glitch.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (cnt_reg == FULL_LAST) begin
                    cnt_next            = '0;
                    shift_next[idx_reg] = rx_s;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets an immediately following start bit be caught.
                if (cnt_reg == FULL_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    assign data_out    = data_reg;
    assign data_valid  = valid_reg;
    assign frame_error = ferr_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: expected bytes are queued as frames are sent and checked on data_valid.
module tb_uart_receiver;

    localparam int BIT_NS = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         dv_count = 0;
    int         fe_count = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_receiver #(.CLKS_PER_BIT(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = stop_bit;
        #(BIT_NS);
    endtask

    task automatic wait_drain(input string tag);
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Scoreboard side: every data_valid pulse consumes one expected byte.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (data_valid) begin
            dv_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_b = exp_q.pop_front();
                check("rx_byte", data_out, exp_b);
            end
            check("valid_width", dv_prev, 0);
        end
        if (frame_error) fe_count++;
        if (data_valid || frame_error) check("valid_ferr_excl", data_valid & frame_error, 0);
        dv_prev = data_valid;
    end

    initial begin
        int dv0, fe0;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", data_valid, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_busy", busy, 0);
        #15 rst = 1'b0;
        #200;

        // Single frame 0xAA
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        wait_drain("drain_aa");
        check("aa_dv_count", dv_count, 1);
        check("aa_fe_count", fe_count, 0);

        // Idle gap: data_out must hold its value
        for (int i = 0; i < 4; i++) begin
            #500;
            check("hold_aa", data_out, 8'hAA);
        end
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_drain("drain_55");
        check("55_dv_count", dv_count, 2);
        check("55_data_out", data_out, 8'h55);
        #300;

        // Three-cycle glitch is a false start
        dv0 = dv_count;
        fe0 = fe_count;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_set", busy, 1);
        repeat (5) @(negedge clk);
        check("glitch_busy_clear", busy, 0);
        #300;
        check("glitch_no_valid", dv_count, dv0);
        check("glitch_no_ferr", fe_count, fe0);

        // Bad stop bit, then recovery
        send_frame(8'hC3, 1'b0);
        rx = 1'b1;
        #300;
        check("ferr_count", fe_count, fe0 + 1);
        check("ferr_no_valid", dv_count, dv0);
        check("ferr_data_hold", data_out, 8'h55);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_drain("drain_3c");
        check("3c_data_out", data_out, 8'h3C);
        #300;

        // Back-to-back frames with no idle gap
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("drain_b2b");
        check("b2b_dv_count", dv_count, 5);
        #300;

        // Reset during bit 4 of a frame
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h5A >> i) & 1;
            #(BIT_NS);
        end
        rx = 1'b1;
        #50 rst = 1'b1;
        #1;
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_valid", data_valid, 0);
        check("midrst_ferr", frame_error, 0);
        check("midrst_busy", busy, 0);
        #49 rst = 1'b0;
        @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_data_out", data_out, 8'h00);
        #200;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_drain("drain_5a");
        check("5a_data_out", data_out, 8'h5A);
        #300;

        check("total_dv", dv_count, 6);
        check("total_fe", fe_count, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, clock cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rx  input  1  asynchronous serial line; idle high.
REQ-005 data_out  output  8  last correctly framed byte received.
REQ-006 data_valid  output  1  one-cycle pulse: new byte on data_out.
REQ-007 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 busy  output  1  high while not in IDLE.

Function
REQ-009 Frame format is 8N1: start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-010 rx passes through a 2-flop synchronizer reset to 1; all FSM decisions use the synchronized value rx_s.
REQ-011 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 IDLE: when rx_s = 0, clear the bit-cycle counter and go to START.
REQ-013 START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE as a false start, with no outputs pulsed.
REQ-014 DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit index 0..7 (LSB first); after bit 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles, sample rx_s; 1 -> data_out <= assembled byte, data_valid = 1 for exactly one cycle, -> IDLE; 0 -> frame_error = 1 for one cycle, data_out unchanged, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_s = 1, then -> IDLE; no start detection while in WAIT_HIGH.
REQ-017 data_valid and frame_error are registered, never high together, and assert in the cycle after the stop-bit sample.
REQ-018 data_out holds its value between valid frames.
REQ-019 Returning to IDLE at mid-stop-bit allows a start bit immediately following the stop bit; back-to-back frames are received without loss.
REQ-020 Bit counter width is $clog2(CLKS_PER_BIT); index counter is 3 bits.
REQ-021 Sampling tolerates a total transmitter/receiver rate mismatch of +/-4%.

Reset
REQ-022 Asserting rst at any time, including mid-frame, forces: state IDLE, counters 0, shift register 0, data_out 8'h00, data_valid 0, frame_error 0, busy 0, synchronizer flops 1.
REQ-023 After reset release, a partially received frame is discarded; reception resumes at the next falling edge of rx_s.

Structure
REQ-024 A shared package uart_pkg holds the FSM state enum and the default CLKS_PER_BIT constant.
REQ-025 The design is a single module; the 2-flop synchronizer may be a sub-module sync_2ff.

Verification
REQ-026 Timing for all scenarios: 10 ns clock, CLKS_PER_BIT = 10, 100 ns per bit, rst high for 50 ns, then idle high for 200 ns.
REQ-027 Send 8'b10101010 -> exactly one data_valid pulse, data_out = 8'hAA, frame_error stays 0.
REQ-028 Wait 2000 ns, then send 8'b01010101 -> one data_valid pulse, data_out = 8'h55; between frames data_out holds 8'hAA.
REQ-029 Drive rx low for 3 cycles, then high -> no data_valid, no frame_error, busy returns to 0 within 6 cycles.
REQ-030 Send 8'hC3 with the stop bit driven 0, then rx high -> one frame_error pulse, no data_valid, data_out unchanged; a following 8'h3C is received correctly.
REQ-031 Send bytes 8'h01 and 8'hFF back-to-back with no idle gap -> two data_valid pulses, values in that order.
REQ-032 Assert rst during bit 4 of a frame, then release -> all outputs 0 immediately; the next full frame 8'h5A is received correctly.
